// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from the FIFO and sends it as a UART frame; start bit on tx one cycle after the pop.
// Frame = (10 + parity + extra stop) * BIT_CYCLES cycles; pops only when idle, tx_en=1 and the FIFO is non-empty.
module fifo_uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_pop_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_bit, par_nxt;
  logic          tx_nxt, done_nxt;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign tx_busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    par_nxt   = par_bit;
    fifo_pop  = 1'b0;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;

    if (state != ST_IDLE) begin
      cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (tx_en && !fifo_empty && !rst) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_pop_data;
          // parity taken from the byte as popped; the shift register is consumed later
          par_nxt   = (^fifo_pop_data) ^ ODD;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // idx counts stop bits so the baud counter stays one bit period wide
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // tx is registered, so it is driven from the state being entered
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_nxt[0];
      ST_PARITY: tx_nxt = par_nxt;
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
